uart_recv_ram: RTL

//  UART receiver, 8N1, LSB first; the receive-side counterpart of the board's RAM-fed UART transmitter.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 37 +++
 rtl/uart_recv_ram.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive blocks: FSM encoding and default link timing.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DEF_CLK_FREQ = 50000000;
  localparam int unsigned DEF_UART_BPS = 115200;

  // RAM write window: 512 bytes, 9-bit address.
  localparam int unsigned RAM_AW = 9;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus a third flop for falling-edge detection.
// All flops preset to 1 so that leaving reset on an idle-high line never looks like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd_async,
  output logic rxd_sync,
  output logic rxd_fall
);

  logic sync1_q, sync2_q, sync3_q;
  logic sync1_d, sync2_d, sync3_d;

  // Next-state of the synchroniser chain: plain shift.
  always_comb begin
    sync1_d = rxd_async;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
  end

  // Synchroniser and edge-detect flops, preset high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
    end
  end

  assign rxd_sync = sync2_q;
  assign rxd_fall = sync3_q & ~sync2_q;

endmodule

// File: rtl/uart_recv_ram.sv
// 8N1 UART receiver that writes every good byte into an external 512x8 RAM write port.
// Write contract: ram_wr_en is a one-cycle strobe with no back-pressure; ram_addr and ram_din
// are valid in that same cycle and the RAM must accept the write unconditionally.
module uart_recv_ram
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned UART_BPS = DEF_UART_BPS
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              uart_rxd,
  input  logic              buf_clr,
  output logic [7:0]        uart_data,
  output logic              uart_done,
  output logic              frame_err,
  output logic              ram_wr_en,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              buf_full,
  output logic              overflow,
  output uart_state_e       dbg_state
);

  localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int unsigned CW      = $clog2(BPS_CNT);
  localparam logic [CW-1:0] BIT_END  = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BPS_CNT / 2 - 1);

  logic rx_sync, rx_fall;

  uart_rx_sync u_sync (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .rxd_async (uart_rxd),
    .rxd_sync  (rx_sync),
    .rxd_fall  (rx_fall)
  );

  uart_state_e       state_q, state_d;
  logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        uart_data_q, uart_data_d;
  logic              uart_done_q, uart_done_d;
  logic              frame_err_q, frame_err_d;
  logic              ram_wr_en_q, ram_wr_en_d;
  logic [7:0]        ram_din_q, ram_din_d;
  logic [RAM_AW:0]   wr_cnt_q, wr_cnt_d;
  logic              overflow_q, overflow_d;
  logic              full;

  // Pointer bit 9 set means all 512 locations have been written.
  assign full = wr_cnt_q[RAM_AW];

  // Frame FSM, bit timing, shift register and write-pointer next-state.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    uart_data_d = uart_data_q;
    uart_done_d = 1'b0;
    frame_err_d = 1'b0;
    ram_wr_en_d = 1'b0;
    ram_din_d   = ram_din_q;
    overflow_d  = overflow_q;
    // Pointer advances the cycle after each write strobe.
    wr_cnt_d    = ram_wr_en_q ? wr_cnt_q + 10'd1 : wr_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (rx_fall) state_d = ST_START;
      end
      ST_START: begin
        if (clk_cnt_q == HALF_END) begin
          clk_cnt_d = '0;
          // A line already back high at mid-start was a glitch.
          state_d   = rx_sync ? ST_IDLE : ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            state_d   = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d = '0;
          // Leave at mid-stop so a back-to-back start edge half a bit later is caught.
          state_d   = ST_IDLE;
          if (rx_sync) begin
            uart_done_d = 1'b1;
            uart_data_d = shift_q;
            if (!buf_clr) begin
              if (full) begin
                overflow_d = 1'b1;
              end else begin
                ram_wr_en_d = 1'b1;
                ram_din_d   = shift_q;
              end
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Host rewind beats any write or overflow decided this cycle.
    if (buf_clr) begin
      wr_cnt_d   = '0;
      overflow_d = 1'b0;
    end
  end

  // All receiver state and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      uart_data_q <= '0;
      uart_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      ram_wr_en_q <= 1'b0;
      ram_din_q   <= '0;
      wr_cnt_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      uart_data_q <= uart_data_d;
      uart_done_q <= uart_done_d;
      frame_err_q <= frame_err_d;
      ram_wr_en_q <= ram_wr_en_d;
      ram_din_q   <= ram_din_d;
      wr_cnt_q    <= wr_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  assign uart_data = uart_data_q;
  assign uart_done = uart_done_q;
  assign frame_err = frame_err_q;
  assign ram_wr_en = ram_wr_en_q;
  assign ram_din   = ram_din_q;
  // Once full the address parks on the last location.
  assign ram_addr  = full ? {RAM_AW{1'b1}} : wr_cnt_q[RAM_AW-1:0];
  assign buf_full  = full;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule
